mem_access_stage: RTL and testbench

//  MEM stage of the ARM pipeline. Sits between the EX/MEM register and the data-memory pipeline register.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over req/ack, stalls upstream while pending, formats load data.
// Define MEM_BYTE_ACCESS_EN to enable byte (LDRB/STRB) lane handling; otherwise all accesses are words.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic [31:0]               ex_addr,
  input  logic [31:0]               ex_store_data,
  input  logic [3:0]                ex_rd,
  input  logic                      ex_load,
  input  logic                      ex_store,
  input  logic                      ex_byte,
  input  logic                      ex_link,
  input  logic                      ex_wb_en,
  output logic                      stall,
  mem_access_stage_if.master        dmem,
  output logic [31:0]               dataMemOut,
  output logic [3:0]                rd_out,
  output logic                      link_out,
  output logic                      wb_en_out,
  output logic                      mem_err
);

`ifdef MEM_BYTE_ACCESS_EN
  localparam logic BYTE_EN = 1'b1;
`else
  localparam logic BYTE_EN = 1'b0;
`endif

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [3:0]   rd_q, rd_d;
  logic         link_q, link_d;
  logic         wb_en_q, wb_en_d;
  logic         load_q, load_d;
  logic         store_q, store_d;
  logic         byte_q, byte_d;
  logic         abort_q, abort_d;
  logic         err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic         mem_op;
  logic [31:0]  load_fmt;
  logic [7:0]   lane_byte;

  assign mem_op    = ex_valid & (ex_load | ex_store);
  assign lane_byte = dmem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign load_fmt  = byte_q ? {24'h0, lane_byte} : dmem.mem_rdata;
  assign mem_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      link_q  <= 1'b0;
      wb_en_q <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      byte_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      link_q  <= link_d;
      wb_en_q <= wb_en_d;
      load_q  <= load_d;
      store_q <= store_d;
      byte_q  <= byte_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    link_d  = link_q;
    wb_en_d = wb_en_q;
    load_d  = load_q;
    store_d = store_q;
    byte_d  = byte_q;
    abort_d = abort_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    stall          = 1'b0;
    dmem.mem_req   = 1'b0;
    dmem.mem_we    = 1'b0;
    dmem.mem_addr  = '0;
    dmem.mem_wdata = '0;
    dmem.mem_be    = '0;
    dataMemOut     = addr_q;
    rd_out         = rd_q;
    link_out       = link_q;
    wb_en_out      = 1'b0;

    unique case (state_q)
      IDLE: begin
        dataMemOut = ex_addr;
        rd_out     = ex_rd;
        link_out   = ex_link;
        wb_en_out  = ex_valid & ex_wb_en;
        if (mem_op) begin
          stall     = 1'b1;
          wb_en_out = 1'b0;
          addr_d    = ex_addr;
          wdata_d   = ex_store_data;
          rd_d      = ex_rd;
          link_d    = ex_link;
          wb_en_d   = ex_wb_en;
          // load+store together behaves as a store, so it never writes back
          load_d    = ex_load & ~ex_store;
          store_d   = ex_store;
          byte_d    = ex_byte & BYTE_EN;
          abort_d   = 1'b0;
          rdata_d   = '0;
          cnt_d     = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        stall          = 1'b1;
        dmem.mem_req   = 1'b1;
        dmem.mem_we    = store_q;
        dmem.mem_addr  = {addr_q[31:2], 2'b00};
        dmem.mem_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
        dmem.mem_be    = byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
        if (dmem.mem_ack) begin
          rdata_d = load_fmt;
          state_d = COMPLETE;
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          abort_d = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPLETE: begin
        dataMemOut = load_q ? rdata_q : addr_q;
        wb_en_out  = wb_en_q & load_q & ~abort_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level reference model and memory responder.
module tb_mem_access_stage;

`ifdef MEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif
  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store, ex_byte, ex_link, ex_wb_en;
  logic [31:0] ex_addr, ex_store_data;
  logic [3:0]  ex_rd;
  logic        stall, link_out, wb_en_out, mem_err;
  logic [31:0] dataMemOut;
  logic [3:0]  rd_out;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_err = 1'b0;

  mem_access_stage_if dmem_if ();

  mem_access_stage #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_store(ex_store), .ex_byte(ex_byte), .ex_link(ex_link),
    .ex_wb_en(ex_wb_en), .stall(stall), .dmem(dmem_if.master),
    .dataMemOut(dataMemOut), .rd_out(rd_out), .link_out(link_out),
    .wb_en_out(wb_en_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference formatting from the architectural rules (little-endian lanes)
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] rdata, input bit is_byte);
    int lane;
    lane = int'(addr % 4);
    if (is_byte) return (rdata >> (8 * lane)) & 32'hFF;
    return rdata;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input bit is_byte);
    int lane;
    lane = int'(addr % 4);
    if (!is_byte) return 4'hF;
    return 4'(1 << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] data, input bit is_byte);
    if (!is_byte) return data;
    return (data & 32'hFF) * 32'h01010101;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // waits: ACCESS cycles without ack before ack arrives; >= MAXW means memory never answers
  task automatic do_txn(input bit v, input bit ld, input bit st, input bit by, input bit wb, input bit lk,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rd,
                        input int waits, input logic [31:0] rdata);
    bit is_mem, is_load, eb, got_ack;
    logic [31:0] exp_data;
    ex_valid = v; ex_load = ld; ex_store = st; ex_byte = by; ex_wb_en = wb; ex_link = lk;
    ex_addr = addr; ex_store_data = data; ex_rd = rd;
    dmem_if.mem_ack = 1'b0;
    dmem_if.mem_rdata = $urandom;
    is_mem  = v && (ld || st);
    is_load = ld && !st;
    eb      = by && BYTE_EN;
    if (!is_mem) begin
      @(negedge clk);
      check("pass_data", dataMemOut, addr);
      check("pass_rd", 32'(rd_out), 32'(rd));
      check("pass_link", 32'(link_out), 32'(lk));
      check("pass_wb", 32'(wb_en_out), 32'(v && wb));
      check("pass_stall", 32'(stall), 32'd0);
      check("pass_req", 32'(dmem_if.mem_req), 32'd0);
      next_cycle();
      return;
    end
    // first cycle: request recognised, bubble, stray ack must be ignored
    dmem_if.mem_ack = 1'($urandom % 2);
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_wb", 32'(wb_en_out), 32'd0);
    check("idle_req", 32'(dmem_if.mem_req), 32'd0);
    next_cycle();
    got_ack = 1'b0;
    for (int j = 0; j < MAXW; j++) begin
      got_ack = (waits < MAXW) && (j == waits);
      dmem_if.mem_ack = got_ack;
      dmem_if.mem_rdata = got_ack ? rdata : $urandom;
      @(negedge clk);
      check("acc_req", 32'(dmem_if.mem_req), 32'd1);
      check("acc_stall", 32'(stall), 32'd1);
      check("acc_wb", 32'(wb_en_out), 32'd0);
      check("acc_we", 32'(dmem_if.mem_we), 32'(st));
      check("acc_addr", dmem_if.mem_addr, addr & ~32'd3);
      check("acc_be", 32'(dmem_if.mem_be), 32'(ref_be(addr, eb)));
      if (st) check("acc_wdata", dmem_if.mem_wdata, ref_wdata(data, eb));
      next_cycle();
      if (got_ack) break;
    end
    if (!got_ack) exp_err = 1'b1;
    dmem_if.mem_ack = 1'($urandom % 2);
    dmem_if.mem_rdata = $urandom;
    exp_data = is_load ? (got_ack ? ref_load(addr, rdata, eb) : 32'd0) : addr;
    @(negedge clk);
    check("cpl_stall", 32'(stall), 32'd0);
    check("cpl_req", 32'(dmem_if.mem_req), 32'd0);
    check("cpl_data", dataMemOut, exp_data);
    check("cpl_rd", 32'(rd_out), 32'(rd));
    check("cpl_link", 32'(link_out), 32'(lk));
    check("cpl_wb", 32'(wb_en_out), 32'(wb && is_load && got_ack));
    check("cpl_err", 32'(mem_err), 32'(exp_err));
    next_cycle();
  endtask

  initial begin
    reset = 1'b1;
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_byte = 0; ex_link = 0; ex_wb_en = 0;
    ex_addr = '0; ex_store_data = '0; ex_rd = '0;
    dmem_if.mem_ack = 1'b0; dmem_if.mem_rdata = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_req", 32'(dmem_if.mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb", 32'(wb_en_out), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_be", 32'(dmem_if.mem_be), 32'd0);
    next_cycle();
    reset = 1'b0;

    do_txn(1, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 4'd3, 0, 32'h0);
    do_txn(1, 1, 0, 0, 1, 0, 32'h100, 32'h0, 4'd5, 2, 32'hDEADBEEF);
    do_txn(1, 0, 1, 1, 1, 0, 32'h103, 32'hAB, 4'd2, 0, 32'h0);
    do_txn(1, 1, 0, 1, 1, 1, 32'h102, 32'h0, 4'd7, 1, 32'h11223344);
    do_txn(1, 1, 1, 0, 1, 0, 32'h208, 32'h55AA55AA, 4'd9, 0, 32'hCAFEF00D);
    do_txn(0, 1, 0, 0, 1, 1, 32'h300, 32'h0, 4'd1, 0, 32'h0);
    do_txn(1, 1, 0, 0, 1, 0, 32'h400, 32'h0, 4'd6, MAXW, 32'h0);
    do_txn(1, 1, 0, 0, 1, 0, 32'h404, 32'h0, 4'd6, MAXW - 1, 32'h89ABCDEF);

    // reset during ACCESS abandons the access and clears mem_err
    ex_valid = 1; ex_load = 1; ex_store = 0; ex_byte = 0; ex_wb_en = 1; ex_link = 0;
    ex_addr = 32'h500; ex_rd = 4'd4; dmem_if.mem_ack = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; ex_valid = 0; dmem_if.mem_ack = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(dmem_if.mem_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_err", 32'(mem_err), 32'd0);
    next_cycle();
    @(negedge clk);
    check("late_ack_req", 32'(dmem_if.mem_req), 32'd0);
    check("late_ack_data", dataMemOut, 32'h500);
    next_cycle();

    for (int i = 0; i < 80; i++) begin
      int w;
      w = ($urandom % 12 == 0) ? MAXW : int'($urandom_range(0, 4));
      do_txn(1'($urandom % 8 != 0), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 4 != 0), 1'($urandom % 2), $urandom, $urandom, 4'($urandom),
             w, $urandom);
    end
    @(negedge clk);
    check("final_err", 32'(mem_err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
